// File: rtl/commit_trace_fifo.sv
// +----------------------------------------------------------------------------+
// | commit_trace_fifo: captures retired-instruction records into a FWFT FIFO   |
// | and drains them over valid/ready, with sequence and drop accounting.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic [4:0]                 commit_rd,
  input  logic                       commit_wen,
  input  logic [31:0]                commit_wdata,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [4:0]                 trace_rd,
  output logic                       trace_wen,
  output logic [31:0]                trace_wdata,
  output logic [CNT_W-1:0]           trace_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [4:0]       rd_mem    [DEPTH];
  logic             wen_mem   [DEPTH];
  logic [31:0]      wdata_mem [DEPTH];
  logic [CNT_W-1:0] seq_mem   [DEPTH];

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNT_W-1:0] seq_ctr;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic keep_wr;

  assign full        = (count == FULL_CNT);
  assign trace_valid = (count != '0);
  assign pop         = trace_valid & trace_ready & ~clear;
  assign push        = commit_valid & (~full | pop) & ~clear;
  assign drop        = commit_valid & full & ~pop & ~clear;
  // x0 is never reported as written, so the write is dropped at capture
  assign keep_wr     = commit_wen & (commit_rd != 5'd0);

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wptr]    <= commit_pc;
      rd_mem[wptr]    <= commit_rd;
      wen_mem[wptr]   <= keep_wr;
      wdata_mem[wptr] <= keep_wr ? commit_wdata : 32'd0;
      seq_mem[wptr]   <= seq_ctr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_ctr  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_ctr  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (commit_valid) seq_ctr <= seq_ctr + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Payload is zeroed while empty so nothing stale leaks to the consumer
  assign trace_pc    = trace_valid ? pc_mem[rptr]    : 32'd0;
  assign trace_rd    = trace_valid ? rd_mem[rptr]    : 5'd0;
  assign trace_wen   = trace_valid ? wen_mem[rptr]   : 1'b0;
  assign trace_wdata = trace_valid ? wdata_mem[rptr] : 32'd0;
  assign trace_seq   = trace_valid ? seq_mem[rptr]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_commit_trace_fifo: directed self-checking bench for commit_trace_fifo.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_commit_trace_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic        commit_wen;
  logic [31:0] commit_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic        trace_wen;
  logic [31:0] trace_wdata;
  logic [15:0] trace_seq;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  commit_trace_fifo #(.DEPTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_rd(commit_rd),
    .commit_wen(commit_wen), .commit_wdata(commit_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_wen(trace_wen),
    .trace_wdata(trace_wdata), .trace_seq(trace_seq),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd,
                        input logic wen, input logic [31:0] wdata);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_rd    = rd;
    commit_wen   = wen;
    commit_wdata = wdata;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; commit_valid = 1'b0; trace_ready = 1'b0;
    commit_pc = 32'h0; commit_rd = 5'd0; commit_wen = 1'b0; commit_wdata = 32'h0;
    #2;
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", trace_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_flags got=%0b/%0d exp=0/0", overflow, drop_cnt); end
    checks++; if (trace_pc !== 32'h0 || trace_seq !== 16'h0) begin failures++; $display("FAIL reset_payload got=%h/%h exp=0/0", trace_pc, trace_seq); end
    @(negedge clock);
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_commit();
    trace_ready = 1'b1;
    commit(32'h8000_0000, 5'd5, 1'b1, 32'h0000_1234);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", trace_valid); end
    checks++; if (trace_pc !== 32'h8000_0000) begin failures++; $display("FAIL single_pc got=%h exp=80000000", trace_pc); end
    checks++; if (trace_rd !== 5'd5 || trace_wen !== 1'b1) begin failures++; $display("FAIL single_rd_wen got=%0d/%0b exp=5/1", trace_rd, trace_wen); end
    checks++; if (trace_wdata !== 32'h1234 || trace_seq !== 16'd0) begin failures++; $display("FAIL single_data_seq got=%h/%0d exp=1234/0", trace_wdata, trace_seq); end
    step();
    checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL single_drained got=%0b/%0d exp=0/0", trace_valid, count); end
    trace_ready = 1'b0;
  endtask

  task automatic test_x0_normalise();
    commit(32'h0000_0200, 5'd0, 1'b1, 32'hDEAD_BEEF);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_wen !== 1'b0 || trace_wdata !== 32'h0 || trace_rd !== 5'd0) begin failures++; $display("FAIL x0_norm got=%0b/%h/%0d exp=0/0/0", trace_wen, trace_wdata, trace_rd); end
    checks++; if (trace_seq !== 16'd1 || trace_pc !== 32'h200) begin failures++; $display("FAIL x0_seq got=%0d/%h exp=1/200", trace_seq, trace_pc); end
    // wen=0 on a non-zero rd also forces stored data to zero; popped concurrently
    trace_ready = 1'b1;
    commit(32'h0000_0204, 5'd4, 1'b0, 32'h0000_0077);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_seq !== 16'd2 || trace_pc !== 32'h204 || count !== 4'd1) begin failures++; $display("FAIL x0_next got=%0d/%h/%0d exp=2/204/1", trace_seq, trace_pc, count); end
    checks++; if (trace_wen !== 1'b0 || trace_wdata !== 32'h0 || trace_rd !== 5'd4) begin failures++; $display("FAIL wen0_norm got=%0b/%h/%0d exp=0/0/4", trace_wen, trace_wdata, trace_rd); end
    step();
    trace_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      commit(32'h100 + 32'(4*i), 5'(i+1), 1'b1, 32'(i));
      step();
    end
    commit_valid = 1'b0;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_flags got=%0b/%0d exp=1/2", overflow, drop_cnt); end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_seq !== 16'(i) || trace_pc !== 32'h100 + 32'(4*i) || trace_wdata !== 32'(i))
      begin failures++; $display("FAIL ovf_drain%0d got=%0b/%0d/%h/%h exp=1/%0d/%h/%h", i, trace_valid, trace_seq, trace_pc, trace_wdata, i, 32'h100 + 32'(4*i), i); end
      step();
    end
    trace_ready = 1'b0;
    checks++; if (trace_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_after got=%0b/%0b/%0d exp=0/1/2", trace_valid, overflow, drop_cnt); end
    commit(32'h300, 5'd1, 1'b1, 32'h1);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_seq !== 16'd10 || trace_pc !== 32'h300) begin failures++; $display("FAIL ovf_seq_gap got=%0d/%h exp=10/300", trace_seq, trace_pc); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      commit(32'h400 + 32'(4*i), 5'd2, 1'b1, 32'h10 + 32'(i));
      step();
    end
    commit_valid = 1'b0;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
    trace_ready = 1'b1;
    commit(32'h500, 5'd3, 1'b1, 32'hCAFE);
    step();
    commit_valid = 1'b0;
    trace_ready = 1'b0;
    checks++; if (count !== 4'd8 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL full_pushpop got=%0d/%0d/%0b exp=8/0/0", count, drop_cnt, overflow); end
    // payload holds while stalled
    step();
    checks++; if (trace_pc !== 32'h404 || trace_seq !== 16'd1) begin failures++; $display("FAIL full_stall got=%h/%0d exp=404/1", trace_pc, trace_seq); end
    trace_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    trace_ready = 1'b0;
    checks++; if (trace_pc !== 32'h500 || trace_seq !== 16'd8 || trace_wdata !== 32'hCAFE || count !== 4'd1) begin failures++; $display("FAIL full_last got=%h/%0d/%h/%0d exp=500/8/cafe/1", trace_pc, trace_seq, trace_wdata, count); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 9; i++) begin
      commit(32'h600 + 32'(4*i), 5'd6, 1'b1, 32'(i));
      step();
    end
    commit_valid = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    trace_ready = 1'b0;
    checks++; if (count !== 4'd5 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin failures++; $display("FAIL clr_pre got=%0d/%0b/%0d exp=5/1/1", count, overflow, drop_cnt); end
    clear = 1'b1; trace_ready = 1'b1;
    commit(32'h6F0, 5'd7, 1'b1, 32'h99);
    step();
    clear = 1'b0; commit_valid = 1'b0; trace_ready = 1'b0;
    checks++; if (count !== 4'd0 || trace_valid !== 1'b0) begin failures++; $display("FAIL clr_empty got=%0d/%0b exp=0/0", count, trace_valid); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL clr_flags got=%0b/%0d exp=0/0", overflow, drop_cnt); end
    commit(32'h704, 5'd8, 1'b1, 32'h5);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_seq !== 16'd0 || trace_pc !== 32'h704) begin failures++; $display("FAIL clr_seq got=%0d/%h exp=0/704", trace_seq, trace_pc); end
  endtask

  task automatic test_async_reset();
    commit(32'h708, 5'd8, 1'b1, 32'h6);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1 || count !== 4'd2) begin failures++; $display("FAIL ar_pre got=%0b/%0d exp=1/2", trace_valid, count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ar_now got=%0b/%0d exp=0/0", trace_valid, count); end
    checks++; if (trace_pc !== 32'h0 || trace_rd !== 5'd0 || trace_wdata !== 32'h0) begin failures++; $display("FAIL ar_payload got=%h/%0d/%h exp=0/0/0", trace_pc, trace_rd, trace_wdata); end
    @(negedge clock);
    reset = 1'b0;
    commit(32'h9000_0000, 5'd9, 1'b1, 32'hABCD);
    step();
    commit_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h9000_0000 || trace_seq !== 16'd0 || count !== 4'd1) begin failures++; $display("FAIL ar_after got=%0b/%h/%0d/%0d exp=1/90000000/0/1", trace_valid, trace_pc, trace_seq, count); end
    checks++; if (trace_wdata !== 32'hABCD || trace_rd !== 5'd9 || trace_wen !== 1'b1) begin failures++; $display("FAIL ar_data got=%h/%0d/%0b exp=abcd/9/1", trace_wdata, trace_rd, trace_wen); end
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_x0_normalise();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Commit-trace collector at the consumer end of the writeback stage. Each cycle it captures one retired-instruction record: PC, destination register, write enable and write data, exactly as presented by writeback. It buffers records in a first-word-fall-through FIFO and drains them to a trace/difftest consumer over a valid/ready handshake. Sequence numbering, overflow and drop accounting let the consumer detect lost commits.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 16, width of sequence and drop counters
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- clear  in  1  synchronous flush of FIFO, counters and flags
- commit_valid  in  1  retired instruction present this cycle
- commit_pc  in  32  PC of retired instruction
- commit_rd  in  5  destination register index
- commit_wen  in  1  register write enable (already qualified by valid upstream)
- commit_wdata  in  32  value written to rd
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_pc  out  32  head PC
- trace_rd  out  5  head rd
- trace_wen  out  1  head write enable
- trace_wdata  out  32  head write data
- trace_seq  out  CNT_W  head commit sequence number
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one commit dropped
- drop_cnt  out  CNT_W  dropped commits, saturating

## Operation
- Record = {pc, rd, wen, wdata, seq}. Normalisation at capture: if commit_rd==0 or commit_wen==0, the stored wen=0 and wdata=0. x0 is never reported as written.
- seq_ctr increments by 1, wrapping modulo 2^CNT_W, on every commit_valid cycle, whether the commit is stored or dropped. A stored record carries the pre-increment value. Dropped commits therefore appear as gaps in trace_seq.
- pop = trace_valid & trace_ready.
- push accepted = commit_valid & (count<DEPTH | pop).
  - Full with a simultaneous pop accepts the push; count is unchanged.
- Drop = commit_valid & count==DEPTH & !pop.
  - overflow is set sticky.
  - drop_cnt increments, saturating at all-ones.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Empty FIFO: trace_valid=0 and all trace_* payload outputs are forced to 0. There is no same-cycle bypass from commit to trace.
- clear has priority over everything in the same cycle:
  - pointers, count, seq_ctr, overflow and drop_cnt go to 0;
  - a concurrent commit is discarded, not counted and not dropped;
  - a concurrent pop has no effect.

## Timing
- Reset (async assert): trace_valid=0, trace_* payload=0, count=0, overflow=0, drop_cnt=0, seq_ctr=0, pointers=0. All outputs settle without a clock edge.
- Deassertion of reset is sampled on the next rising edge; the first commit can be captured on that edge.
- Latency: commit sampled at edge N; record visible on trace_* after edge N (one cycle). It leaves after the edge where pop=1.
- Throughput: one push and one pop per cycle, sustained.
- trace_* payload is stable while trace_valid=1 and trace_ready=0.
- Status outputs (count, overflow, drop_cnt) are registered and update on the same edge as the push or pop that changes them.

## Test plan
- Single commit:
  - Stimulus: pc=0x8000_0000, rd=5, wen=1, wdata=0x0000_1234; trace_ready=1.
  - Required: next cycle trace_valid=1, trace_pc=0x8000_0000, trace_rd=5, trace_wen=1, trace_wdata=0x1234, trace_seq=0. The following cycle trace_valid=0, count=0.
- x0 normalisation:
  - Stimulus: commit rd=0, wen=1, wdata=0xDEAD_BEEF.
  - Required: trace_wen=0, trace_wdata=0, trace_rd=0; seq still advances.
- Overflow:
  - Stimulus: trace_ready=0; 10 back-to-back commits with pc=0x100+4i.
  - Required: count=8, overflow=1, drop_cnt=2. Drain yields seq 0..7, pc 0x100..0x11C. The next commit carries seq=10.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; commit while trace_ready=1.
  - Required: no drop, drop_cnt unchanged, count stays 8. The new record appears last in drain order.
- Clear mid-operation:
  - Stimulus: count=5, overflow=1; assert clear together with commit_valid.
  - Required: next cycle count=0, trace_valid=0, overflow=0, drop_cnt=0. The next commit has seq=0.
- Async reset mid-drain:
  - Stimulus: assert reset between clock edges while trace_valid=1.
  - Required: trace_valid, payload, count and flags go to 0 immediately. After release, the bench confirms normal capture.
